// File: rtl/sub_shift_rows_if.sv
// sub_shift_rows_if: valid/ready handshake bundle for the
// SubBytes+ShiftRows stage (state in, permuted state out).
interface sub_shift_rows_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/sub_shift_rows.sv
// sub_shift_rows: iterative AES SubBytes + ShiftRows,
// LANES shared S-boxes, 16/LANES cycles per block.
module sub_shift_rows #(
    parameter int LANES = 4
) (
    input logic             clk,
    input logic             rst_n,
    sub_shift_rows_if.slave bus
);

    if (!(LANES inside {1, 2, 4, 8, 16})) begin : g_bad_lanes
        $error("sub_shift_rows: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [3:0] STEP = 4'(LANES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[8*(255-int'(x)) +: 8];
    endfunction

    state_t         state;
    state_t         state_nx;
    logic [3:0]     idx;
    logic [127:0]   work;
    logic [127:0]   work_sub;
    logic [127:0]   shifted;
    logic           last;
    logic           accept;
    logic           in_ready_w;
    logic           out_valid_w;
    logic           busy_w;

    // LANES=16 makes STEP wrap to 0, so idx simply stays at 0.
    assign last   = ({1'b0, idx} + 5'(LANES)) == 5'd16;
    assign accept = bus.in_valid && in_ready_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.in_valid) state_nx = SUB;
            SUB:     if (last) state_nx = DONE;
            DONE:    if (bus.out_ready)
                         state_nx = bus.in_valid ? SUB : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready_w  = 1'b0;
        out_valid_w = 1'b0;
        busy_w      = 1'b0;
        unique case (state)
            IDLE: in_ready_w = rst_n;
            SUB:  busy_w = 1'b1;
            DONE: begin
                out_valid_w = 1'b1;
                in_ready_w  = rst_n && bus.out_ready;
            end
            default: ;
        endcase
    end

    always_comb begin
        int p;
        p        = 0;
        work_sub = work;
        for (int l = 0; l < LANES; l++) begin
            p = 127 - 8*(int'(idx) + l);
            work_sub[p -: 8] = sbox(work[p -: 8]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work <= '0;
            idx  <= '0;
        end else if (accept) begin
            work <= bus.in_data;
            idx  <= '0;
        end else if (state == SUB) begin
            work <= work_sub;
            idx  <= idx + STEP;
        end
    end

    // Out byte (r,c) takes work byte (r,(c+r) mod 4).
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127-8*(4*c+r) -: 8] =
                    work[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.busy      = busy_w;
    assign bus.out_data  = shifted;

endmodule

// File: tb/tb_sub_shift_rows.sv
// tb_sub_shift_rows: directed vectors for the iterative
// SubBytes+ShiftRows stage, LANES=4 plus a LANES sweep.
module tb_sub_shift_rows;

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam int LV [4] = '{1, 2, 8, 16};

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sub_shift_rows_if b();

    sub_shift_rows #(.LANES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    logic         sw_valid;
    logic         sw_ov [4];
    logic [127:0] sw_od [4];

    for (genvar g = 0; g < 4; g++) begin : g_sw
        sub_shift_rows_if sb();
        assign sb.in_valid  = sw_valid;
        assign sb.in_data   = '0;
        assign sb.out_ready = 1'b0;
        assign sw_ov[g]     = sb.out_valid;
        assign sw_od[g]     = sb.out_data;
        sub_shift_rows #(.LANES(LV[g])) u (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (sb)
        );
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!b.out_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic accept(input logic [127:0] v);
        b.in_data  = v;
        b.in_valid = 1'b1;
        tick();
        b.in_valid = 1'b0;
    endtask

    logic [127:0] vin  [3];
    logic [127:0] vexp [3];
    logic [127:0] held;
    int           n;
    int           lat [4];

    initial begin
        vin[0]  = '0;            vexp[0] = {16{8'h63}};
        vin[1]  = {16{8'h53}};   vexp[1] = {16{8'hed}};
        vin[2]  = FIPS_IN;       vexp[2] = FIPS_OUT;

        rst_n      = 1'b0;
        b.in_valid = 1'b0;
        b.in_data  = '0;
        b.out_ready = 1'b0;
        sw_valid   = 1'b0;
        repeat (2) tick();

        chk("rst_in_ready", 128'(b.in_ready), 128'd0);
        chk("rst_out_valid", 128'(b.out_valid), 128'd0);
        chk("rst_busy", 128'(b.busy), 128'd0);
        chk("rst_out_data", b.out_data, 128'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 128'(b.in_ready), 128'd1);

        // FIPS-197 round 1, then 10 cycles of backpressure
        accept(FIPS_IN);
        chk("fips_busy", 128'(b.busy), 128'd1);
        wait_out(n);
        chk("fips_lat", 128'(n + 1), 128'd4 + 128'd1);
        chk("fips_data", b.out_data, FIPS_OUT);
        held = b.out_data;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_data", b.out_data, held);
            chk("bp_in_ready", 128'(b.in_ready), 128'd0);
            chk("bp_busy", 128'(b.busy), 128'd0);
            chk("bp_valid", 128'(b.out_valid), 128'd1);
        end
        b.out_ready = 1'b1;
        tick();
        chk("bp_release", 128'(b.out_valid), 128'd0);
        chk("bp_idle_ready", 128'(b.in_ready), 128'd1);

        // back-to-back, in_valid held high
        b.in_data  = vin[0];
        b.in_valid = 1'b1;
        tick();
        b.in_data = vin[1];
        for (int k = 0; k < 3; k++) begin
            chk("b2b_sub_ready", 128'(b.in_ready), 128'd0);
            wait_out(n);
            chk("b2b_lat", 128'(n), 128'd4);
            chk("b2b_data", b.out_data, vexp[k]);
            chk("b2b_done_ready", 128'(b.in_ready), 128'd1);
            if (k == 2) b.in_valid = 1'b0;
            tick();
            if (k == 0) b.in_data = vin[2];
        end
        chk("b2b_end_valid", 128'(b.out_valid), 128'd0);

        // all-zero sweep over the other LANES values
        for (int g = 0; g < 4; g++) lat[g] = 0;
        sw_valid = 1'b1;
        tick();
        sw_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            for (int g = 0; g < 4; g++)
                if (sw_ov[g] && lat[g] == 0) lat[g] = c;
        end
        chk("sw1_lat", 128'(lat[0]), 128'd16);
        chk("sw2_lat", 128'(lat[1]), 128'd8);
        chk("sw8_lat", 128'(lat[2]), 128'd2);
        chk("sw16_lat", 128'(lat[3]), 128'd1);
        for (int g = 0; g < 4; g++)
            chk("sw_data", sw_od[g], {16{8'h63}});

        // reset two cycles into SUB
        b.in_data  = FIPS_IN;
        b.in_valid = 1'b1;
        tick();
        b.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(b.out_valid), 128'd0);
        chk("mid_rst_busy", 128'(b.busy), 128'd0);
        chk("mid_rst_ready", 128'(b.in_ready), 128'd0);
        tick();
        rst_n = 1'b1;
        #1;
        accept({16{8'h01}});
        wait_out(n);
        chk("post_rst_lat", 128'(n), 128'd4);
        chk("post_rst_data", b.out_data, {16{8'h7c}});
        tick();

        // in_valid/in_data toggling while substituting
        accept({16{8'h10}});
        n = 0;
        while (!b.out_valid && n < 100) begin
            b.in_valid = 1'($urandom_range(0, 1));
            b.in_data  = {$urandom, $urandom, $urandom, $urandom};
            chk("tog_in_ready", 128'(b.in_ready), 128'd0);
            tick();
            n++;
        end
        b.in_valid = 1'b0;
        chk("tog_lat", 128'(n), 128'd4);
        chk("tog_data", b.out_data, {16{8'hca}});
        tick();
        chk("tog_end_valid", 128'(b.out_valid), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
